// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch handshake between the PC/fetch unit (master) and instruction memory (slave).
interface pc_fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC owner for the multicycle datapath: fetch handshake, PC/IPC registers, next-PC redirects.
// Optional PC_ALIGN_CHECK_EN adds adel_o and blocks misaligned redirect targets.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] LINK_OFFSET = 32'd4
) (
  input  logic                   clk,
  input  logic                   reset,
  pc_fetch_unit_if.master        imem,
  input  logic                   fetch_req_i,
  input  logic                   pc_wr_i,
  input  logic [1:0]             npc_sel_i,
  input  logic                   branch_take_i,
  input  logic [31:0]            ext_imm16_i,
  input  logic [31:0]            ext_imm26_i,
  input  logic [31:0]            rs_val_i,
  output logic                   fetch_done_o,
  output logic                   busy_o,
  output logic [31:0]            pc_o,
  output logic [31:0]            ipc_o,
  output logic [31:0]            link_o
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                   adel_o
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] redirectTarget;
  logic        redirectReq;
  logic        redirectLoad;
  logic        fetchStart;
  logic        unusedImm26Bits;

  // The upper nibble of the jump field is always replaced by the IPC region bits.
  assign unusedImm26Bits = ^ext_imm26_i[31:28];

  // Every target is formed relative to the instruction currently in IR.
  always_comb begin
    redirectTarget = pc_q;
    case (npc_sel_i)
      2'b01: if (branch_take_i) redirectTarget = ipc_q + 32'd4 + (ext_imm16_i << 2);
      2'b10: redirectTarget = {ipc_q[31:28], ext_imm26_i[27:0]};
      2'b11: redirectTarget = rs_val_i;
      default: redirectTarget = pc_q;
    endcase
  end

  assign redirectReq = (state_q == IDLE) && pc_wr_i;

`ifdef PC_ALIGN_CHECK_EN
  logic adel_q, adel_d;
  logic misaligned;
  logic adelSet;

  assign misaligned   = (redirectTarget[1:0] != 2'b00);
  assign adelSet      = redirectReq && misaligned;
  assign redirectLoad = redirectReq && !misaligned;
  // A fault raised on this edge also suppresses a fetch requested on the same edge.
  assign fetchStart   = (state_q == IDLE) && fetch_req_i && !adel_q && !adelSet;
  assign adel_d       = adel_q | adelSet;
  assign adel_o       = adel_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adel_q <= 1'b0;
    end else begin
      adel_q <= adel_d;
    end
  end
`else
  assign redirectLoad = redirectReq;
  assign fetchStart   = (state_q == IDLE) && fetch_req_i;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    case (state_q)
      IDLE: begin
        if (redirectLoad) pc_d = redirectTarget;
        if (fetchStart) state_d = REQ;
      end
      REQ: begin
        if (imem.imem_ready_i) begin
          ipc_d   = pc_q;
          pc_d    = pc_q + 32'd4;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ipc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
    end
  end

  assign imem.imem_req_o  = (state_q == REQ);
  assign imem.imem_addr_o = pc_q;
  assign fetch_done_o     = (state_q == DONE);
  assign busy_o           = (state_q != IDLE);
  assign pc_o             = pc_q;
  assign ipc_o            = ipc_q;
  assign link_o           = ipc_q + LINK_OFFSET;

endmodule
